store_retire_buffer: RTL



---
 rtl/store_retire_buffer_pkg.sv | 20 ++
 rtl/store_retire_buffer_fwd_match.sv | 37 +++
 rtl/store_retire_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/store_retire_buffer_pkg.sv
// Shared types and default sizing for the store retire buffer.
package store_retire_buffer_pkg;

  localparam int unsigned STB_DEPTH  = 4;
  localparam int unsigned STB_ADDR_W = 32;
  localparam int unsigned STB_DATA_W = 32;
  localparam int unsigned STB_BE_W   = STB_DATA_W / 8;

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
    logic [STB_BE_W-1:0]   be;
  } stb_entry_t;

  typedef enum logic {
    STB_IDLE = 1'b0,
    STB_BUSY = 1'b1
  } stb_state_e;

endpackage

// File: rtl/store_retire_buffer_fwd_match.sv
// Youngest-first word-address match of a load against the pending store entries.
module stb_fwd_match #(
  parameter int DEPTH   = 4,
  parameter int WADDR_W = 30,
  parameter int BE_W    = 4
) (
  input  logic [WADDR_W-1:0]       waddr_i [DEPTH],
  input  logic [BE_W-1:0]          be_i    [DEPTH],
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [$clog2(DEPTH)-1:0] tail_i,
  input  logic [WADDR_W-1:0]       ld_waddr_i,
  output logic                     match_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     full_word_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk from the oldest slot (tail) towards the youngest (tail-1); last hit wins.
  always_comb begin
    match_o     = 1'b0;
    idx_o       = '0;
    full_word_o = 1'b0;
    slot        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = tail_i + PTR_W'(k);
      if (valid_i[slot] && (waddr_i[slot] == ld_waddr_i)) begin
        match_o     = 1'b1;
        idx_o       = slot;
        full_word_o = &be_i[slot];
      end
    end
  end

endmodule

// File: rtl/store_retire_buffer.sv
// Post-commit store FIFO draining to data memory, with load conflict check.
// Define STB_LD_FWD_EN to forward full-word store data to matching loads.
module store_retire_buffer
  import store_retire_buffer_pkg::*;
#(
  parameter int DEPTH  = STB_DEPTH,
  parameter int ADDR_W = STB_ADDR_W,
  parameter int DATA_W = STB_DATA_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       retire_st_valid,
  input  logic [ADDR_W-1:0]          retire_st_addr,
  input  logic [DATA_W-1:0]          retire_st_data,
  input  logic [DATA_W/8-1:0]        retire_st_be,
  output logic                       retire_st_ready,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_be,
  input  logic                       mem_ack,
  input  logic                       ld_chk_valid,
  input  logic [ADDR_W-1:0]          ld_chk_addr,
  output logic                       ld_fwd_hit,
  output logic [DATA_W-1:0]          ld_fwd_data,
  output logic                       ld_stall,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, off;
  logic [CNT_W-1:0]  count_q, count_d, remain;
  stb_state_e        state_q, state_d;
  logic              enq, deq, load_head;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-3:0] st_waddr [DEPTH];
  logic              fm_match, fm_full;
  logic [PTR_W-1:0]  fm_idx;

  assign full            = (count_q == CNT_W'(DEPTH));
  assign empty           = (count_q == '0);
  assign count           = count_q;
  assign retire_st_ready = !full;
  assign mem_req         = (state_q == STB_BUSY);
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_be          = mem_be_q;

  assign enq     = retire_st_valid && retire_st_ready;
  assign deq     = mem_req && mem_ack;
  assign head_d  = head_q + PTR_W'(deq);
  assign tail_d  = tail_q + PTR_W'(enq);
  assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  assign remain  = count_q - CNT_W'(deq);

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    case (state_q)
      STB_IDLE: begin
        if (count_d != '0) begin
          state_d   = STB_BUSY;
          load_head = 1'b1;
        end
      end
      STB_BUSY: begin
        if (mem_ack) begin
          if (count_d != '0) load_head = 1'b1;
          else               state_d   = STB_IDLE;
        end
      end
      default: state_d = STB_IDLE;
    endcase
  end

  // When nothing older survives this edge, the new head is the store arriving now.
  always_comb begin
    mem_addr_d  = addr_q[head_d];
    mem_wdata_d = data_q[head_d];
    mem_be_d    = be_q[head_d];
    if (remain == '0) begin
      mem_addr_d  = retire_st_addr;
      mem_wdata_d = retire_st_data;
      mem_be_d    = retire_st_be;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= STB_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (load_head) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        mem_be_q    <= mem_be_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      addr_q[tail_q] <= retire_st_addr;
      data_q[tail_q] <= retire_st_data;
      be_q[tail_q]   <= retire_st_be;
    end
  end

  always_comb begin
    valid    = '0;
    off      = '0;
    st_waddr = '{default: '0};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - head_q;
      valid[i]    = (CNT_W'(off) < count_q);
      st_waddr[i] = addr_q[i][ADDR_W-1:2];
    end
  end

  stb_fwd_match #(
    .DEPTH   (DEPTH),
    .WADDR_W (ADDR_W - 2),
    .BE_W    (BE_W)
  ) u_fwd_match (
    .waddr_i     (st_waddr),
    .be_i        (be_q),
    .valid_i     (valid),
    .tail_i      (tail_q),
    .ld_waddr_i  (ld_chk_addr[ADDR_W-1:2]),
    .match_o     (fm_match),
    .idx_o       (fm_idx),
    .full_word_o (fm_full)
  );

`ifdef STB_LD_FWD_EN
  assign ld_fwd_hit  = ld_chk_valid && fm_match && fm_full;
  assign ld_fwd_data = ld_fwd_hit ? data_q[fm_idx] : '0;
  assign ld_stall    = ld_chk_valid && fm_match && !fm_full;
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_stall    = ld_chk_valid && fm_match;
  logic unused_fwd;
  assign unused_fwd  = ^{fm_idx, fm_full};
`endif

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_chk_addr[1:0];

endmodule
